// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcode/funct
// fields, datapath select codes and the decoder's instruction-class one-hot layout.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXE    = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] WB_ALU   = 3'b000;
    localparam logic [2:0] WB_DM    = 3'b001;
    localparam logic [2:0] WB_PC4   = 3'b010;
    localparam logic [2:0] WB_EXT   = 3'b011;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_RA   = 2'b10;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_BR    = 2'b01;
    localparam logic [1:0] PC_JUMP  = 2'b10;
    localparam logic [1:0] PC_JR    = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;
    localparam logic [1:0] ALU_LUI  = 2'b11;

    localparam int CLS_ADDU = 0;
    localparam int CLS_SUBU = 1;
    localparam int CLS_JR   = 2;
    localparam int CLS_ORI  = 3;
    localparam int CLS_LW   = 4;
    localparam int CLS_SW   = 5;
    localparam int CLS_BEQ  = 6;
    localparam int CLS_LUI  = 7;
    localparam int CLS_J    = 8;
    localparam int CLS_JAL  = 9;
    localparam int CLS_W    = 10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to a one-hot class plus legal flag.
// Zero latency, no flow control.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]       i_opcode,
    input  logic [5:0]       i_funct,
    output logic [CLS_W-1:0] o_cls,
    output logic             o_legal
);

    always_comb begin
        o_cls = '0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU: o_cls[CLS_ADDU] = 1'b1;
                    FN_SUBU: o_cls[CLS_SUBU] = 1'b1;
                    FN_JR:   o_cls[CLS_JR]   = 1'b1;
                    default: o_cls = '0;
                endcase
            end
            OP_ORI:  o_cls[CLS_ORI] = 1'b1;
            OP_LW:   o_cls[CLS_LW]  = 1'b1;
            OP_SW:   o_cls[CLS_SW]  = 1'b1;
            OP_BEQ:  o_cls[CLS_BEQ] = 1'b1;
            OP_LUI:  o_cls[CLS_LUI] = 1'b1;
            OP_J:    o_cls[CLS_J]   = 1'b1;
            OP_JAL:  o_cls[CLS_JAL] = 1'b1;
            default: o_cls = '0;
        endcase
        o_legal = |o_cls;
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXE/MEM/WB), Mealy outputs, 2-5 cycles
// per instruction; no backpressure, counts retired legal instructions.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             ir_write,
    output logic             rf_write,
    output logic             dm_write,
    output logic [2:0]       wb_sel,
    output logic [1:0]       dst_sel,
    output logic             alub_sel,
    output logic [1:0]       alu_op,
    output logic             ext_op,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_retire;
    logic [CLS_W-1:0]   w_cls;
    logic               w_legal;
    logic               w_is_r;

    mc_decode u_decode (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_cls    (w_cls),
        .o_legal  (w_legal)
    );

    assign w_is_r    = w_cls[CLS_ADDU] | w_cls[CLS_SUBU];
    assign instr_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next   = ST_FETCH;
        w_retire = 1'b0;
        pc_write = 1'b0;
        pc_sel   = PC_PLUS4;
        ir_write = 1'b0;
        rf_write = 1'b0;
        dm_write = 1'b0;
        wb_sel   = WB_ALU;
        dst_sel  = DST_RT;
        alub_sel = 1'b0;
        alu_op   = ALU_ADD;
        ext_op   = 1'b0;
        illegal  = 1'b0;
        // Reset masks every output so an aborted instruction cannot commit anything.
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = ST_DECODE;
                end
                ST_DECODE: begin
                    if (!w_legal) begin
                        illegal = 1'b1;
                    end else if (w_cls[CLS_J] | w_cls[CLS_JAL]) begin
                        pc_write = 1'b1;
                        pc_sel   = PC_JUMP;
                        w_retire = 1'b1;
                        if (w_cls[CLS_JAL]) begin
                            rf_write = 1'b1;
                            dst_sel  = DST_RA;
                            wb_sel   = WB_PC4;
                        end
                    end else if (w_cls[CLS_JR]) begin
                        pc_write = 1'b1;
                        pc_sel   = PC_JR;
                        w_retire = 1'b1;
                    end else begin
                        w_next = ST_EXE;
                    end
                end
                ST_EXE: begin
                    if (w_cls[CLS_SUBU] | w_cls[CLS_BEQ]) alu_op = ALU_SUB;
                    else if (w_cls[CLS_ORI])              alu_op = ALU_OR;
                    else if (w_cls[CLS_LUI])              alu_op = ALU_LUI;
                    alub_sel = w_cls[CLS_ORI] | w_cls[CLS_LUI] | w_cls[CLS_LW] | w_cls[CLS_SW];
                    ext_op   = w_cls[CLS_LW] | w_cls[CLS_SW] | w_cls[CLS_BEQ];
                    if (w_cls[CLS_BEQ]) begin
                        pc_sel   = PC_BR;
                        pc_write = zero;
                        w_retire = 1'b1;
                    end else if (w_cls[CLS_LW] | w_cls[CLS_SW]) begin
                        w_next = ST_MEM;
                    end else begin
                        w_next = ST_WB;
                    end
                end
                ST_MEM: begin
                    if (w_cls[CLS_SW]) begin
                        dm_write = 1'b1;
                        w_retire = 1'b1;
                    end else begin
                        w_next = ST_WB;
                    end
                end
                ST_WB: begin
                    rf_write = 1'b1;
                    dst_sel  = w_is_r ? DST_RD : DST_RT;
                    wb_sel   = w_cls[CLS_LW] ? WB_DM : WB_ALU;
                    w_retire = 1'b1;
                end
                default: w_next = ST_FETCH;
            endcase
        end
    end

endmodule
